// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive frame sequencer and the line/sampler/checker side.
// The master modport is the sequencer; the slave modport is everything around it.
interface uart_rx_ctrl_if #(
  parameter int Prescale_Width = 6
);
  logic                      rx_in;
  logic                      par_en;
  logic [Prescale_Width-1:0] prescale;
  logic                      strt_glitch;
  logic                      par_err;
  logic                      stp_err;
  logic [Prescale_Width-1:0] edge_cnt;
  logic [3:0]                bit_cnt;
  logic                      dat_samp_en;
  logic                      strt_chk_en;
  logic                      deser_en;
  logic                      par_chk_en;
  logic                      stp_chk_en;
  logic                      data_valid;
  logic                      frame_err;
  logic                      busy;

  modport master (
    input  rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, busy
  );

  modport slave (
    output rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: walks start/data/parity/stop bits at the latched
// oversampling ratio, strobes the checkers and deserializer, and judges each frame.
module uart_rx_ctrl #(
  parameter int Data_Width     = 8,
  parameter int Prescale_Width = 6
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, OUT} state_t;

  localparam logic [3:0]                LastData = 4'(Data_Width);
  localparam logic [Prescale_Width-1:0] MinPs    = Prescale_Width'(4);

  state_t                    state, next_state;
  logic [Prescale_Width-1:0] edge_q, edge_d;
  logic [Prescale_Width-1:0] ps_q, ps_d;
  logic [Prescale_Width-1:0] ps_last, ps_chk;
  logic [3:0]                bit_q, bit_d;
  logic                      err_q, err_d;
  logic                      ferr_q, ferr_d;
  logic                      last_edge;

  assign ps_last   = ps_q - Prescale_Width'(1);
  assign ps_chk    = ps_q - Prescale_Width'(2);
  assign last_edge = (edge_q == ps_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      edge_q <= '0;
      bit_q  <= '0;
      ps_q   <= MinPs;
      err_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state  <= next_state;
      edge_q <= edge_d;
      bit_q  <= bit_d;
      ps_q   <= ps_d;
      err_q  <= err_d;
      ferr_q <= ferr_d;
    end
  end

  // Every bit lasts exactly PS cycles; decisions are taken on the last edge of a bit,
  // one cycle after the matching checker was strobed, so its registered result is ready.
  always_comb begin
    next_state = state;
    edge_d     = edge_q;
    bit_d      = bit_q;
    ps_d       = ps_q;
    err_d      = err_q;
    ferr_d     = 1'b0;

    case (state)
      IDLE, OUT: begin
        edge_d = '0;
        bit_d  = '0;
        if (state == OUT) begin
          err_d = 1'b0;
        end
        if (!bus.rx_in) begin
          next_state = START;
          ps_d       = (bus.prescale < MinPs) ? MinPs : bus.prescale;
        end else begin
          next_state = IDLE;
        end
      end

      default: begin
        if (last_edge) begin
          edge_d = '0;
          bit_d  = bit_q + 4'd1;
        end else begin
          edge_d = edge_q + Prescale_Width'(1);
        end

        case (state)
          START: begin
            if (last_edge) begin
              if (bus.strt_glitch) begin
                next_state = IDLE;
                bit_d      = '0;
              end else begin
                next_state = DATA;
              end
            end
          end
          DATA: begin
            if (last_edge && (bit_q == LastData)) begin
              next_state = bus.par_en ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (last_edge) begin
              err_d      = bus.par_err;
              next_state = STOP;
            end
          end
          STOP: begin
            if (last_edge) begin
              bit_d = '0;
              if (bus.stp_err || err_q) begin
                ferr_d     = 1'b1;
                err_d      = 1'b0;
                next_state = IDLE;
              end else begin
                next_state = OUT;
              end
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.dat_samp_en = (state == START) || (state == DATA) ||
                           (state == PARITY) || (state == STOP);
  assign bus.strt_chk_en = (state == START)  && (edge_q == ps_chk);
  assign bus.deser_en    = (state == DATA)   && last_edge;
  assign bus.par_chk_en  = (state == PARITY) && (edge_q == ps_chk);
  assign bus.stp_chk_en  = (state == STOP)   && (edge_q == ps_chk);
  assign bus.data_valid  = (state == OUT);
  assign bus.frame_err   = ferr_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame table, hand-built corner sequences,
// then randomized traffic compared against a frame-timing model built from bit arithmetic.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart_rx_ctrl_if #(.Prescale_Width(PW)) bus ();

  uart_rx_ctrl #(.Data_Width(DW), .Prescale_Width(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int prescale;
    bit par_en;
    bit sg;
    bit pe;
    bit se;
    int first_deser;
    int deser_cnt;
    int par_chk;
    int stp_chk;
    int dv;
    int fe;
  } vec_t;

  typedef struct {
    int first_deser;
    int deser_cnt;
    int par_chk;
    int stp_chk;
    int dv;
    int fe;
    int dv_cnt;
    int fe_cnt;
  } ev_t;

  // reference model: frame position is cycles since the start bit began
  bit m_in_frame, m_out, m_fe, m_par, m_perr;
  int m_k, m_ps;

  function automatic vec_t mkVec(int ps, bit par, bit sg, bit pe, bit se,
                                 int fd, int dc, int pc, int sc, int dv, int fe);
    vec_t v;
    v.prescale = ps; v.par_en = par; v.sg = sg; v.pe = pe; v.se = se;
    v.first_deser = fd; v.deser_cnt = dc; v.par_chk = pc; v.stp_chk = sc;
    v.dv = dv; v.fe = fe;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rx, input bit par, input int ps,
                               input bit sg, input bit pe, input bit se);
    bus.rx_in       = rx;
    bus.par_en      = par;
    bus.prescale    = PW'(ps);
    bus.strt_glitch = sg;
    bus.par_err     = pe;
    bus.stp_err     = se;
  endtask

  function automatic int dutWord();
    return int'({bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en,
                 bus.deser_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid,
                 bus.frame_err, bus.busy});
  endfunction

  function automatic int modelExpect();
    int e, b, stpb;
    logic [5:0] ev;
    logic [3:0] bv;
    bit dat, strt, des, par, stp, dv, busy;
    e = 0; b = 0; dat = 0; strt = 0; des = 0; par = 0; stp = 0; dv = 0; busy = 0;
    if (m_in_frame) begin
      e    = m_k % m_ps;
      b    = m_k / m_ps;
      stpb = m_par ? DW + 2 : DW + 1;
      dat  = 1; busy = 1;
      strt = (b == 0) && (e == m_ps - 2);
      des  = (b >= 1) && (b <= DW) && (e == m_ps - 1);
      par  = (b > DW) && m_par && (b == DW + 1) && (e == m_ps - 2);
      stp  = (b > DW) && (b == stpb) && (e == m_ps - 2);
    end
    if (m_out) begin
      dv = 1; busy = 1;
    end
    ev = 6'(e);
    bv = 4'(b);
    return int'({ev, bv, dat, strt, des, par, stp, dv, m_fe, busy});
  endfunction

  task automatic modelStep();
    bit nf, no, nfe;
    int nk, e, b, ps;
    nf = m_in_frame; no = 0; nfe = 0; nk = m_k + 1;
    if (rst) begin
      m_in_frame = 0; m_out = 0; m_fe = 0; m_k = 0; m_perr = 0;
      return;
    end
    if (m_in_frame) begin
      e = m_k % m_ps;
      b = m_k / m_ps;
      if (e == m_ps - 1) begin
        if (b == 0 && bus.strt_glitch) nf = 0;
        else if (b == DW) m_par = bus.par_en;
        else if (b == DW + 1 && m_par) m_perr = bus.par_err;
        else if (b == (m_par ? DW + 2 : DW + 1)) begin
          nf = 0;
          if (bus.stp_err || m_perr) nfe = 1; else no = 1;
        end
      end
    end else if (!bus.rx_in) begin
      ps = int'(bus.prescale);
      nf = 1; nk = 0; m_ps = (ps < 4) ? 4 : ps; m_perr = 0;
    end
    m_in_frame = nf; m_out = no; m_fe = nfe; m_k = nk;
  endtask

  task automatic runFrame(input vec_t v, output ev_t r);
    int limit;
    limit = 12 * ((v.prescale < 4) ? 4 : v.prescale) + 4;
    r = '{-1, 0, -1, -1, -1, -1, 0, 0};
    applyStimulus(1, v.par_en, v.prescale, v.sg, v.pe, v.se);
    @(negedge clk);
    bus.rx_in = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (k == 2) bus.rx_in = 1'b1;
      if (bus.deser_en) begin
        if (r.deser_cnt == 0) r.first_deser = k;
        r.deser_cnt++;
      end
      if (bus.par_chk_en && r.par_chk < 0) r.par_chk = k;
      if (bus.stp_chk_en && r.stp_chk < 0) r.stp_chk = k;
      if (bus.data_valid) begin
        if (r.dv < 0) r.dv = k;
        r.dv_cnt++;
      end
      if (bus.frame_err) begin
        if (r.fe < 0) r.fe = k;
        r.fe_cnt++;
      end
    end
    applyStimulus(1, 0, 8, 0, 0, 0);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    ev_t  r;
    int   dv1, dv2, cnt, found;

    total = 0;
    bad   = 0;
    vecs[0] = mkVec( 8, 0, 0, 0, 0,  15, 8,  -1,  78,  80,  -1);
    vecs[1] = mkVec(16, 1, 0, 1, 0,  31, 8, 158, 174,  -1, 176);
    vecs[2] = mkVec( 8, 0, 1, 0, 0,  -1, 0,  -1,  -1,  -1,  -1);
    vecs[3] = mkVec( 2, 0, 0, 0, 0,   7, 8,  -1,  38,  40,  -1);
    vecs[4] = mkVec( 8, 1, 0, 0, 0,  15, 8,  78,  86,  88,  -1);
    vecs[5] = mkVec( 8, 0, 0, 0, 1,  15, 8,  -1,  78,  -1,  80);
    vecs[6] = mkVec( 8, 0, 0, 1, 0,  15, 8,  -1,  78,  80,  -1);
    vecs[7] = mkVec(63, 1, 0, 0, 0, 125, 8, 628, 691, 693,  -1);

    rst = 1'b1;
    applyStimulus(1, 0, 8, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", dutWord(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] directed frame table");
    for (int i = 0; i < 8; i++) begin
      runFrame(vecs[i], r);
      checkOutput($sformatf("v%0d_first_deser", i), r.first_deser, vecs[i].first_deser);
      checkOutput($sformatf("v%0d_deser_cnt", i), r.deser_cnt, vecs[i].deser_cnt);
      checkOutput($sformatf("v%0d_par_chk", i), r.par_chk, vecs[i].par_chk);
      checkOutput($sformatf("v%0d_stp_chk", i), r.stp_chk, vecs[i].stp_chk);
      checkOutput($sformatf("v%0d_dv_time", i), r.dv, vecs[i].dv);
      checkOutput($sformatf("v%0d_fe_time", i), r.fe, vecs[i].fe);
      checkOutput($sformatf("v%0d_dv_cnt", i), r.dv_cnt, (vecs[i].dv >= 0) ? 1 : 0);
      checkOutput($sformatf("v%0d_fe_cnt", i), r.fe_cnt, (vecs[i].fe >= 0) ? 1 : 0);
      repeat (3) @(negedge clk);
    end

    $display("[TB] back-to-back frames");
    applyStimulus(1, 0, 8, 0, 0, 0);
    @(negedge clk);
    bus.rx_in = 1'b0;
    dv1 = -1; dv2 = -1; cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.data_valid) begin
        if (dv1 < 0) dv1 = k;
        else if (dv2 < 0) dv2 = k;
      end
      if (bus.frame_err) cnt++;
      if (dv1 >= 0 && k == dv1 + 1) begin
        checkOutput("b2b_restart_samp", int'(bus.dat_samp_en), 1);
        checkOutput("b2b_restart_cnts", int'({bus.edge_cnt, bus.bit_cnt}), 0);
        bus.rx_in = 1'b1;
      end
    end
    checkOutput("b2b_first_dv", dv1, 80);
    checkOutput("b2b_dv_spacing", dv2 - dv1, 81);
    checkOutput("b2b_no_frame_err", cnt, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 0, 8, 0, 0, 0);
    @(negedge clk);
    bus.rx_in = 1'b0;
    @(negedge clk);
    bus.rx_in = 1'b1;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk);
      if (bus.bit_cnt == 4'd4) begin
        found = 1;
        rst = 1'b1;
      end
    end
    checkOutput("rst_reached_bit4", found, 1);
    @(negedge clk);
    checkOutput("rst_all_zero", dutWord(), 0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (bus.data_valid || bus.frame_err) cnt++;
    end
    checkOutput("rst_no_pulses", cnt, 0);
    runFrame(vecs[0], r);
    checkOutput("post_rst_dv", r.dv, 80);
    checkOutput("post_rst_deser_cnt", r.deser_cnt, 8);

    $display("[TB] prescale change mid-frame");
    applyStimulus(1, 0, 8, 0, 0, 0);
    @(negedge clk);
    bus.rx_in = 1'b0;
    dv1 = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 1) bus.rx_in = 1'b1;
      if (bus.busy && bus.bit_cnt == 4'd3) bus.prescale = PW'(16);
      if (bus.data_valid && dv1 < 0) dv1 = k;
    end
    checkOutput("ps_change_dv", dv1, 80);
    v = vecs[0];
    v.prescale = 16;
    runFrame(v, r);
    checkOutput("ps16_stp_chk", r.stp_chk, 158);
    checkOutput("ps16_dv", r.dv, 160);

    $display("[TB] randomized traffic against model");
    @(negedge clk);
    rst = 1'b1;
    modelStep();
    for (int n = 0; n < 15000; n++) begin
      @(negedge clk);
      checkOutput("random_cycle", dutWord(), modelExpect());
      rst             = ($urandom_range(0, 999) == 0);
      bus.rx_in       = ($urandom_range(0, 3) != 0);
      bus.par_en      = 1'($urandom_range(0, 1));
      bus.prescale    = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 63))
                                                    : PW'($urandom_range(0, 12));
      bus.strt_glitch = ($urandom_range(0, 5) == 0);
      bus.par_err     = ($urandom_range(0, 3) == 0);
      bus.stp_err     = ($urandom_range(0, 4) == 0);
      modelStep();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
